// File: rtl/bus_copy_engine.sv
// Bus-master copy engine: moves a block of byte/half/word units from src to dst via read-then-write transactions.
// Optional macro BUS_COPY_ENGINE_TIMEOUT_EN faults a transaction whose bus_ready never arrives within TIMEOUT_CYCLES.
module bus_copy_engine #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [1:0]            size,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  bus_enable,
  output logic                  bus_wr_en,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_o_data,
  output logic [3:0]            bus_be,
  input  logic [DATA_WIDTH-1:0] bus_i_data,
  input  logic                  bus_ready,
  input  logic                  bus_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD_GAP, S_WR, S_WR_GAP, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_src_q, cur_src_d;
  logic [ADDR_WIDTH-1:0] cur_dst_q, cur_dst_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [1:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic [2:0]            unit_bytes;
  logic [3:0]            unit_be;
  logic [DATA_WIDTH-1:0] unit_mask;
  logic                  cfg_bad;
  logic                  tmo_hit;

  always_comb begin
    unit_bytes = 3'd4;
    unit_be    = 4'b1111;
    unit_mask  = '1;
    case (size_q)
      2'd0: begin
        unit_bytes = 3'd1;
        unit_be    = 4'b0001;
        unit_mask  = DATA_WIDTH'(32'h0000_00FF);
      end
      2'd1: begin
        unit_bytes = 3'd2;
        unit_be    = 4'b0011;
        unit_mask  = DATA_WIDTH'(32'h0000_FFFF);
      end
      default: ;
    endcase
  end

  // Configuration is judged on the raw inputs so a bad request never reaches the bus.
  always_comb begin
    cfg_bad = 1'b1;
    case (size)
      2'd0: cfg_bad = 1'b0;
      2'd1: cfg_bad = src_addr[0] | dst_addr[0] | length[0];
      2'd2: cfg_bad = (|src_addr[1:0]) | (|dst_addr[1:0]) | (|length[1:0]);
      default: cfg_bad = 1'b1;
    endcase
  end

`ifdef BUS_COPY_ENGINE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // The counter is zero in every non-transaction state, so entry to RD/WR always starts fresh.
  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if ((state_q == S_RD || state_q == S_WR) && !bus_ready) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) tmo_hit = 1'b1;
      else                                     tmo_d   = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d    = state_q;
    cur_src_d  = cur_src_q;
    cur_dst_d  = cur_dst_q;
    err_addr_d = err_addr_q;
    rem_d      = rem_q;
    size_d     = size_q;
    data_d     = data_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_src_d  = src_addr;
          cur_dst_d  = dst_addr;
          rem_d      = length;
          size_d     = size;
          err_d      = 1'b0;
          err_addr_d = '0;
          if (cfg_bad) begin
            err_d      = 1'b1;
            err_addr_d = src_addr;
            state_d    = S_DONE;
          end else if (length == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (bus_ready && bus_err) begin
          err_d      = 1'b1;
          err_addr_d = cur_src_q;
          state_d    = S_DONE;
        end else if (bus_ready) begin
          data_d  = bus_i_data & unit_mask;
          state_d = S_RD_GAP;
        end else if (tmo_hit) begin
          err_d      = 1'b1;
          err_addr_d = cur_src_q;
          state_d    = S_DONE;
        end
      end
      S_RD_GAP: state_d = S_WR;
      S_WR: begin
        if (bus_ready && bus_err) begin
          err_d      = 1'b1;
          err_addr_d = cur_dst_q;
          state_d    = S_DONE;
        end else if (bus_ready) begin
          cur_src_d = cur_src_q + ADDR_WIDTH'(unit_bytes);
          cur_dst_d = cur_dst_q + ADDR_WIDTH'(unit_bytes);
          rem_d     = rem_q - LEN_WIDTH'(unit_bytes);
          state_d   = S_WR_GAP;
        end else if (tmo_hit) begin
          err_d      = 1'b1;
          err_addr_d = cur_dst_q;
          state_d    = S_DONE;
        end
      end
      S_WR_GAP: state_d = (rem_q != '0) ? S_RD : S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Bus signals are decoded from state so they are exactly zero whenever enable is low.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    bus_enable = 1'b0;
    bus_wr_en  = 1'b0;
    bus_addr   = '0;
    bus_o_data = '0;
    bus_be     = 4'b0000;
    case (state_q)
      S_RD: begin
        busy       = 1'b1;
        bus_enable = 1'b1;
        bus_addr   = cur_src_q;
        bus_be     = unit_be;
      end
      S_WR: begin
        busy       = 1'b1;
        bus_enable = 1'b1;
        bus_wr_en  = 1'b1;
        bus_addr   = cur_dst_q;
        bus_o_data = data_q;
        bus_be     = unit_be;
      end
      S_RD_GAP, S_WR_GAP: busy = 1'b1;
      S_DONE:             done = 1'b1;
      default: ;
    endcase
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_src_q  <= '0;
      cur_dst_q  <= '0;
      err_addr_q <= '0;
      rem_q      <= '0;
      size_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_src_q  <= cur_src_d;
      cur_dst_q  <= cur_dst_d;
      err_addr_q <= err_addr_d;
      rem_q      <= rem_d;
      size_q     <= size_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_bus_copy_engine.sv
// Scoreboard bench for bus_copy_engine: an sp_bram-like responder (ready two cycles after enable)
// and a queue of expected bus transactions built from a shadow memory model.
module tb_bus_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] length;
  logic [1:0]  size;
  logic        busy, done, err;
  logic [31:0] err_addr;
  logic        bus_enable, bus_wr_en;
  logic [31:0] bus_addr, bus_o_data, bus_i_data;
  logic [3:0]  bus_be;
  logic        bus_ready, bus_err;

  bus_copy_engine #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .size(size),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr),
    .bus_enable(bus_enable), .bus_wr_en(bus_wr_en), .bus_addr(bus_addr),
    .bus_o_data(bus_o_data), .bus_be(bus_be), .bus_i_data(bus_i_data),
    .bus_ready(bus_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } txn_t;

  txn_t       exp_q[$];
  int         checks = 0;
  int         passed = 0;
  int         done_cnt = 0;
  int         en_cnt = 0;
  logic [7:0] mem [0:63];
  logic [7:0] model_mem [0:63];
  int         mem_limit = 64;
  bit         no_ready = 1'b0;
  bit         preload = 1'b0;
  bit         wait_cnt;
  bit         gap_due = 1'b0;
  int         r_nb;
  bit         r_ok;
  logic [5:0] r_a;

  function automatic logic [7:0] initByte(int i);
    case (i)
      0: return 8'h44;  1: return 8'h33;  2: return 8'h22;  3: return 8'h11;
      4: return 8'h88;  5: return 8'h77;  6: return 8'h66;  7: return 8'h55;
      default: return 8'h00;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Responder: ready one cycle, two cycles after enable; accesses at or past mem_limit return bus_err.
  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 64; i++) mem[i] <= initByte(i);
    if (rst) begin
      bus_ready  <= 1'b0;
      bus_err    <= 1'b0;
      bus_i_data <= '0;
      wait_cnt   <= 1'b0;
    end else if (bus_ready) begin
      bus_ready <= 1'b0;
      bus_err   <= 1'b0;
      wait_cnt  <= 1'b0;
    end else if (bus_enable && !no_ready) begin
      if (!wait_cnt) wait_cnt <= 1'b1;
      else begin
        r_a  = bus_addr[5:0];
        r_nb = (bus_be == 4'b1111) ? 4 : (bus_be == 4'b0011) ? 2 : 1;
        r_ok = (int'(bus_addr) + r_nb <= mem_limit);
        bus_ready <= 1'b1;
        bus_err   <= !r_ok;
        wait_cnt  <= 1'b0;
        if (!bus_wr_en)
          bus_i_data <= {mem[r_a + 6'd3], mem[r_a + 6'd2], mem[r_a + 6'd1], mem[r_a]};
        else if (r_ok)
          for (int k = 0; k < r_nb; k++) mem[r_a + 6'(k)] <= bus_o_data[8*k +: 8];
      end
    end
  end

  // Monitor: scoreboard pops on every completed transaction and checks the idle gap after it.
  always @(negedge clk) begin
    txn_t e;
    if (rst) gap_due = 1'b0;
    else begin
      if (done) begin
        done_cnt++;
        checkOutput("busy_low_in_done", 64'(busy), 64'(0));
      end
      if (bus_enable) en_cnt++;
      if (gap_due) begin
        checkOutput("gap_enable", 64'(bus_enable), 64'(0));
        checkOutput("gap_bus_idle", 64'({bus_wr_en, bus_be, bus_addr}), 64'(0));
      end
      gap_due = bus_enable && bus_ready;
      if (bus_enable && bus_ready) begin
        if (exp_q.size() == 0) checkOutput("txn_queue_nonempty", 64'(exp_q.size()), 64'(1));
        else begin
          e = exp_q.pop_front();
          checkOutput("txn_wr_en", 64'(bus_wr_en), 64'(e.wr));
          checkOutput("txn_addr", 64'(bus_addr), 64'(e.addr));
          checkOutput("txn_be", 64'(bus_be), 64'(e.be));
          if (e.wr) checkOutput("txn_wdata", 64'(bus_o_data), 64'(e.data));
        end
      end
    end
  end

  task automatic initModel();
    for (int i = 0; i < 64; i++) model_mem[i] = initByte(i);
  endtask

  task automatic pushExpected(input logic [31:0] src, input logic [31:0] dst,
                              input logic [15:0] len, input logic [1:0] sz, input int max_txns);
    int u, n;
    txn_t t;
    logic [31:0] d;
    if (sz == 2'd3) return;
    u = 1 << sz;
    if ((int'(src) % u) != 0 || (int'(dst) % u) != 0 || (int'(len) % u) != 0 || len == 0) return;
    n = 0;
    for (int i = 0; i < int'(len) / u; i++) begin
      if (n >= max_txns) break;
      t.wr = 1'b0; t.addr = src + 32'(i * u);
      t.be = (sz == 2'd0) ? 4'b0001 : (sz == 2'd1) ? 4'b0011 : 4'b1111;
      t.data = '0;
      exp_q.push_back(t); n++;
      d = '0;
      for (int k = 0; k < u; k++) d[8*k +: 8] = model_mem[(int'(t.addr) + k) % 64];
      if (n >= max_txns) break;
      t.wr = 1'b1; t.addr = dst + 32'(i * u); t.data = d;
      exp_q.push_back(t); n++;
      if (int'(t.addr) + u <= mem_limit)
        for (int k = 0; k < u; k++) model_mem[(int'(t.addr) + k) % 64] = d[8*k +: 8];
    end
  endtask

  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst,
                               input logic [15:0] len, input logic [1:0] sz, input bit hold);
    @(negedge clk);
    src_addr = src; dst_addr = dst; length = len; size = sz; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic waitDone(input int max_cyc, output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (cyc >= max_cyc) begin
        checkOutput("done_seen", 64'(done), 64'(1));
        break;
      end
    end
  endtask

  logic [31:0] cf_src [4] = '{32'h11, 32'h0, 32'h4, 32'h0};
  logic [15:0] cf_len [4] = '{16'd2, 16'd6, 16'd4, 16'd0};
  logic [1:0]  cf_sz  [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
  bit          cf_err [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int cyc, d0, e0, k;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0; size = '0;
    preload = 1'b1;
    initModel();
    repeat (3) @(negedge clk);
    preload = 1'b0;
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_err", 64'({err, err_addr}), 64'(0));
    checkOutput("rst_bus", 64'({bus_enable, bus_wr_en, bus_be, bus_addr}), 64'(0));
    checkOutput("rst_wdata", 64'(bus_o_data), 64'(0));
    rst = 1'b0;

    $display("[TB] word copy 0x0 -> 0x10, 8 bytes");
    pushExpected(32'h0, 32'h10, 16'd8, 2'd2, 100);
    d0 = done_cnt;
    applyStimulus(32'h0, 32'h10, 16'd8, 2'd2, 1'b0);
    waitDone(200, cyc);
    checkOutput("word_err", 64'(err), 64'(0));
    @(negedge clk);
    checkOutput("word_done_once", 64'(done_cnt - d0), 64'(1));
    checkOutput("word_queue_empty", 64'(exp_q.size()), 64'(0));
    checkOutput("word_mem_0x10", 64'({mem[19], mem[18], mem[17], mem[16]}), 64'(32'h11223344));
    checkOutput("word_mem_0x14", 64'({mem[23], mem[22], mem[21], mem[20]}), 64'(32'h55667788));

    $display("[TB] byte copy 0x10 -> 0x21, 3 bytes");
    pushExpected(32'h10, 32'h21, 16'd3, 2'd0, 100);
    applyStimulus(32'h10, 32'h21, 16'd3, 2'd0, 1'b0);
    waitDone(200, cyc);
    checkOutput("byte_err", 64'(err), 64'(0));
    @(negedge clk);
    checkOutput("byte_queue_empty", 64'(exp_q.size()), 64'(0));
    checkOutput("byte_mem_0x21", 64'({mem[35], mem[34], mem[33]}), 64'(24'h223344));

    $display("[TB] configuration faults and zero length");
    for (int i = 0; i < 4; i++) begin
      e0 = en_cnt;
      applyStimulus(cf_src[i], 32'h20, cf_len[i], cf_sz[i], 1'b0);
      waitDone(5, cyc);
      checkOutput("cfg_done_latency_ok", 64'(cyc <= 2), 64'(1));
      checkOutput("cfg_err", 64'(err), 64'(cf_err[i]));
      if (cf_err[i]) checkOutput("cfg_err_addr", 64'(err_addr), 64'(cf_src[i]));
      @(negedge clk);
      checkOutput("cfg_no_bus", 64'(en_cnt - e0), 64'(0));
    end

    $display("[TB] bus error on second write");
    mem_limit = 32'h18;
    pushExpected(32'h0, 32'h14, 16'd8, 2'd2, 4);
    applyStimulus(32'h0, 32'h14, 16'd8, 2'd2, 1'b0);
    waitDone(200, cyc);
    checkOutput("buserr_err", 64'(err), 64'(1));
    checkOutput("buserr_err_addr", 64'(err_addr), 64'(32'h18));
    e0 = en_cnt;
    repeat (5) @(negedge clk);
    checkOutput("buserr_no_more_txn", 64'(en_cnt - e0), 64'(0));
    checkOutput("buserr_queue_empty", 64'(exp_q.size()), 64'(0));
    mem_limit = 64;

    $display("[TB] reset during write");
    pushExpected(32'h0, 32'h30, 16'd8, 2'd2, 100);
    applyStimulus(32'h0, 32'h30, 16'd8, 2'd2, 1'b0);
    k = 0;
    while (!(bus_enable && bus_wr_en) && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rstwr_reached_write", 64'(bus_enable && bus_wr_en), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstwr_flags", 64'({busy, done, err}), 64'(0));
    checkOutput("rstwr_bus", 64'({bus_enable, bus_wr_en, bus_be, bus_addr}), 64'(0));
    checkOutput("rstwr_wdata_erraddr", 64'({bus_o_data, err_addr}), 64'(0));
    rst = 1'b0;
    exp_q.delete();
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    checkOutput("rstwr_no_done", 64'(done_cnt - d0), 64'(0));
    checkOutput("rstwr_idle", 64'(busy), 64'(0));
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    initModel();

    $display("[TB] start while busy is ignored");
    pushExpected(32'h0, 32'h30, 16'd8, 2'd2, 100);
    d0 = done_cnt;
    applyStimulus(32'h0, 32'h30, 16'd8, 2'd2, 1'b0);
    repeat (3) @(negedge clk);
    src_addr = 32'h4; dst_addr = 32'h38; length = 16'd1; size = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(200, cyc);
    checkOutput("busystart_err", 64'(err), 64'(0));
    @(negedge clk);
    checkOutput("busystart_done_once", 64'(done_cnt - d0), 64'(1));
    e0 = en_cnt;
    repeat (4) @(negedge clk);
    checkOutput("busystart_no_restart", 64'(en_cnt - e0), 64'(0));
    checkOutput("busystart_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] start held through a transfer");
    pushExpected(32'h0, 32'h38, 16'd4, 2'd2, 100);
    pushExpected(32'h0, 32'h38, 16'd4, 2'd2, 100);
    d0 = done_cnt;
    applyStimulus(32'h0, 32'h38, 16'd4, 2'd2, 1'b1);
    waitDone(100, cyc);
    k = 0;
    while (!busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    checkOutput("hold_restarted", 64'(busy), 64'(1));
    waitDone(100, cyc);
    @(negedge clk);
    checkOutput("hold_two_dones", 64'(done_cnt - d0), 64'(2));
    checkOutput("hold_queue_empty", 64'(exp_q.size()), 64'(0));

`ifdef BUS_COPY_ENGINE_TIMEOUT_EN
    $display("[TB] timeout with silent responder");
    no_ready = 1'b1;
    applyStimulus(32'h8, 32'h30, 16'd4, 2'd2, 1'b0);
    k = 0;
    while (!bus_enable && k < 5) begin
      @(negedge clk);
      k++;
    end
    waitDone(80, cyc);
    checkOutput("tmo_within_66", 64'(cyc <= 66), 64'(1));
    checkOutput("tmo_err", 64'(err), 64'(1));
    checkOutput("tmo_err_addr", 64'(err_addr), 64'(32'h8));
    no_ready = 1'b0;
    repeat (2) @(negedge clk);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passed);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bus_copy_engine.md
Name: bus_copy_engine

Overview:
Bus initiator that copies a block of memory from a source address to a destination address. It speaks the same bus as sp_bram and the other peripherals (enable, wr_en, addr, data, be, ready, bus_err) from the master side. The copy is a sequence of read-then-write transactions in byte, half or word units. It sits beside the CPU as a simple DMA and is controlled by a start pulse and configuration inputs.

Parameters:
ADDR_WIDTH, 32, width of bus address and the src/dst configuration inputs
DATA_WIDTH, 32, bus data width; only 32 is supported
LEN_WIDTH, 16, width of the byte-length input
TIMEOUT_CYCLES, 64, cycles to wait for bus_ready before faulting (optional feature only)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a copy; sampled only in IDLE
src_addr  in  ADDR_WIDTH  byte address of first source unit; latched on accepted start
dst_addr  in  ADDR_WIDTH  byte address of first destination unit; latched on accepted start
length  in  LEN_WIDTH  byte count; latched on accepted start
size  in  2  unit size: 0=byte, 1=half, 2=word, 3=illegal
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at the end of every accepted start, whether it passed or failed
err  out  1  sticky fault flag; cleared on the next accepted start
err_addr  out  ADDR_WIDTH  bus address of the faulting transaction, or src_addr for config faults
bus_enable  out  1  transaction request
bus_wr_en  out  1  1=write, 0=read
bus_addr  out  ADDR_WIDTH  byte address
bus_o_data  out  DATA_WIDTH  write data, right-justified, to responder i_data
bus_be  out  4  byte enables: 0001 byte, 0011 half, 1111 word
bus_i_data  in  DATA_WIDTH  read data from responder o_data, right-justified
bus_ready  in  1  responder completion
bus_err  in  1  responder error, valid with bus_ready

Behaviour:
- Reset (rst high at an edge): state IDLE. All outputs are 0, including err, err_addr and the data registers. Reset mid-copy aborts immediately with no done pulse.
- Unit bytes U = 1, 2 or 4 for size 0, 1 or 2.
- Accepted start (IDLE and start=1): latch src, dst, length and size. Clear err, then check the configuration:
  - size=3, src or dst not a multiple of U, or length not a multiple of U: set err, set err_addr=src_addr, go to DONE. No bus traffic.
  - length=0: go to DONE, err=0, no bus traffic.
  - Otherwise go to RD.
- start while not in IDLE is ignored.
- States: IDLE, RD, RD_GAP, WR, WR_GAP, DONE.
- RD: bus_enable=1, bus_wr_en=0, bus_addr=cur_src, bus_be per size. Outputs are held stable until bus_ready=1 is sampled.
  - On ready with bus_err=0: capture bus_i_data masked to U bytes (upper bytes zero), then go to RD_GAP.
  - On ready with bus_err=1: set err, set err_addr=cur_src, go to DONE.
- RD_GAP: bus_enable=0 for exactly one cycle, then go to WR.
- WR: bus_enable=1, bus_wr_en=1, bus_addr=cur_dst, bus_o_data=captured data, bus_be per size. Held until ready.
  - On ready with bus_err=1: set err, set err_addr=cur_dst, go to DONE.
  - Otherwise cur_src+=U, cur_dst+=U, remaining-=U, then go to WR_GAP.
- WR_GAP: bus_enable=0 for one cycle. Go to RD if remaining≠0, else go to DONE.
- DONE: done=1 for one cycle, busy=0 in this cycle, then go to IDLE.
- bus_wr_en, bus_be and bus_addr are 0 whenever bus_enable=0.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- A fault stops the copy at the first error. Units already written remain written.
- Minimum cost is 2 gap cycles per unit plus responder latency per transaction.

Optional Feature:
BUS_COPY_ENGINE_TIMEOUT_EN
- Defined: a counter clears on entry to RD or WR and increments each cycle bus_ready=0. When it reaches TIMEOUT_CYCLES, drop bus_enable, set err, set err_addr to the current bus_addr, and go to DONE.
- Undefined: no counter; the engine waits for bus_ready indefinitely.

Test Plan:
- Word copy, size=2, src=0x0, dst=0x10, length=8. The responder model is sp_bram-like, with ready 2 cycles after enable and memory preloaded 0x11223344, 0x55667788. Required: bus sequence R0x0, W0x10, R0x4, W0x14, all with be=1111 and one-cycle enable gaps. Memory at 0x10/0x14 matches the source; done pulses once; err=0.
- Byte copy, size=0, src=0x10, dst=0x21, length=3. Required: three reads then writes with be=0001 and bus_o_data upper 24 bits zero; bytes 0x44, 0x33, 0x22 land at 0x21..0x23.
- Config faults: size=1 with src=0x11, then size=2 with length=6, then size=3. Required for each: no bus_enable, done next-but-one cycle, err=1, err_addr=src. length=0 gives done with err=0.
- Bus error: word copy of 8 bytes to dst=0x14 on an 0x18-byte memory. Required: the second write at 0x18 returns bus_err; err=1, err_addr=0x18, no further transactions, done pulse.
- Robustness:
  - Assert rst during WR: all outputs are 0 next cycle and no done pulse.
  - start pulsed while busy has no effect.
  - Hold start through a transfer: a new copy begins only after returning to IDLE.
- With BUS_COPY_ENGINE_TIMEOUT_EN, TIMEOUT_CYCLES=64 and the responder never asserting ready: err=1 and done within 66 cycles of the first enable; err_addr=src.
